keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 222 ++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debounce
// and a one-deep key buffer handed off via valid/ready.
//
// Ports:
//   clk       sole clock, rising edge
//   reset     asynchronous, active-low
//   row_n     row sense lines, active-low, async to clk
//   col_n     column strobes, exactly one bit low
//   key_code  accepted key {row[1:0], col[1:0]}
//   key_valid key_code holds an unconsumed key
//   key_ready consumer takes key_code this cycle
//   key_held  accepted key still physically pressed
//   overrun   one-cycle pulse: new key dropped
module keypad_scanner #(
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row_n,
   output logic [3:0] col_n,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ready,
   output logic       key_held,
   output logic       overrun
);

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      HELD,
      RELEASE
   } state_t;

   localparam logic [3:0] DB_N = 4'(DEBOUNCE_SCANS);

   logic [3:0] row_meta;
   logic [3:0] rows_s;
   logic [7:0] scan_cnt;
   logic [1:0] col_idx;
   logic       sample;
   logic       col_step;
   logic       press;
   logic [1:0] press_row;
   state_t     state;
   state_t     state_nx;
   logic [3:0] cnt;
   logic [3:0] cnt_nx;
   logic [3:0] cnt_inc;
   logic [1:0] row_cap;
   logic [1:0] row_cap_nx;
   logic       accept;
   logic       load;
   logic       drop;
   logic       take;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         row_meta <= 4'hF;
         rows_s   <= 4'hF;
      end else begin
         row_meta <= row_n;
         rows_s   <= row_meta;
      end
   end

   // Sample one cycle before the column moves so the
   // rows have had the whole column slot to settle.
   assign sample   = (scan_cnt == 8'hFE);
   assign col_step = (scan_cnt == 8'hFF) && (state == SCAN);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scan_cnt <= 8'h00;
         col_idx  <= 2'd0;
      end else begin
         scan_cnt <= scan_cnt + 8'd1;
         if (col_step) begin
            col_idx <= col_idx + 2'd1;
         end
      end
   end

   always_comb begin
      col_n = 4'b1110;
      unique case (col_idx)
         2'd0: col_n = 4'b1110;
         2'd1: col_n = 4'b1101;
         2'd2: col_n = 4'b1011;
         2'd3: col_n = 4'b0111;
         default: col_n = 4'b1110;
      endcase
   end

   // Only a single low row is a press; ghosting or
   // multiple keys in one column read as no press.
   always_comb begin
      press     = 1'b0;
      press_row = 2'd0;
      unique case (rows_s)
         4'b1110: begin
            press     = 1'b1;
            press_row = 2'd0;
         end
         4'b1101: begin
            press     = 1'b1;
            press_row = 2'd1;
         end
         4'b1011: begin
            press     = 1'b1;
            press_row = 2'd2;
         end
         4'b0111: begin
            press     = 1'b1;
            press_row = 2'd3;
         end
         default: begin
            press     = 1'b0;
            press_row = 2'd0;
         end
      endcase
   end

   assign cnt_inc = cnt + 4'd1;

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      row_cap_nx = row_cap;
      accept     = 1'b0;
      if (sample) begin
         unique case (state)
            SCAN: begin
               if (press) begin
                  row_cap_nx = press_row;
                  cnt_nx     = 4'd1;
                  if (DB_N == 4'd1) begin
                     state_nx = HELD;
                     accept   = 1'b1;
                  end else begin
                     state_nx = DEBOUNCE;
                  end
               end
            end
            DEBOUNCE: begin
               if (press && press_row == row_cap) begin
                  cnt_nx = cnt_inc;
                  if (cnt_inc == DB_N) begin
                     state_nx = HELD;
                     accept   = 1'b1;
                  end
               end else begin
                  state_nx = SCAN;
               end
            end
            HELD: begin
               // A single quiet sample already
               // completes a release when N is 1.
               if (!press) begin
                  cnt_nx = 4'd1;
                  if (DB_N == 4'd1) begin
                     state_nx = SCAN;
                  end else begin
                     state_nx = RELEASE;
                  end
               end
            end
            RELEASE: begin
               if (!press) begin
                  cnt_nx = cnt_inc;
                  if (cnt_inc == DB_N) begin
                     state_nx = SCAN;
                  end
               end else if (press_row == row_cap) begin
                  state_nx = HELD;
               end
            end
            default: state_nx = SCAN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= SCAN;
         cnt     <= 4'd0;
         row_cap <= 2'd0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         row_cap <= row_cap_nx;
      end
   end

   assign key_held = (state == HELD) || (state == RELEASE);

   // A consume in the accept cycle frees the buffer
   // for the new key, so it loads instead of dropping.
   assign load = accept && (!key_valid || key_ready);
   assign drop = accept && key_valid && !key_ready;
   assign take = !accept && key_valid && key_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         key_code  <= 4'h0;
         key_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         overrun <= 1'b0;
         unique case (1'b1)
            load: begin
               key_code  <= {row_cap_nx, col_idx};
               key_valid <= 1'b1;
            end
            drop: overrun <= 1'b1;
            take: key_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed table, hand sequences and
// random keypad activity against a behavioural model.
module tb_keypad_scanner;

   localparam int D  = 4;
   localparam int NV = 10;

   logic        clk       = 1'b0;
   logic        reset     = 1'b0;
   logic        key_ready = 1'b0;
   logic [15:0] pressed   = 16'h0000;
   logic [3:0]  row_n;
   logic [3:0]  col_n;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;
   logic        overrun;
   logic [10:0] dut_o;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   bit model_chk = 1'b0;

   keypad_scanner #(
      .DEBOUNCE_SCANS(D)
   ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .row_n    (row_n),
      .col_n    (col_n),
      .key_code (key_code),
      .key_valid(key_valid),
      .key_ready(key_ready),
      .key_held (key_held),
      .overrun  (overrun)
   );

   always #5 clk = ~clk;

   assign dut_o = {col_n, key_code, key_valid,
                   key_held, overrun};

   // Physical matrix: a pressed key pulls its row low
   // while its column strobe is low.
   always_comb begin
      row_n = 4'hF;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            if (!col_n[c] && pressed[r*4+c]) begin
               row_n[r] = 1'b0;
            end
         end
      end
   end

   // Behavioural model: counts of agreeing samples.
   logic [7:0] m_cnt;
   logic [1:0] m_col;
   logic [1:0] m_row;
   bit         m_latched;
   int         m_streak;
   int         m_quiet;
   logic       m_valid;
   logic       m_ovr;
   logic [3:0] m_code;

   function automatic logic [3:0] rows_at(
      input logic [15:0] keys, input logic [1:0] c);
      logic [3:0] v;
      v = 4'hF;
      for (int r = 0; r < 4; r++) begin
         if (keys[r*4+int'(c)]) v[r] = 1'b0;
      end
      return v;
   endfunction

   task automatic model_reset();
      m_cnt     = 8'h00;
      m_col     = 2'd0;
      m_row     = 2'd0;
      m_latched = 1'b0;
      m_streak  = 0;
      m_quiet   = 0;
      m_valid   = 1'b0;
      m_ovr     = 1'b0;
      m_code    = 4'h0;
   endtask

   task automatic model_step();
      logic [3:0] rows;
      int         nlow;
      logic [1:0] r;
      bit         acc;
      bit         prs;
      acc  = 1'b0;
      nlow = 0;
      r    = 2'd0;
      if (m_cnt == 8'hFF && !m_latched && m_streak == 0)
         m_col = m_col + 2'd1;
      if (m_cnt == 8'hFE) begin
         rows = rows_at(pressed, m_col);
         for (int i = 0; i < 4; i++) begin
            if (!rows[i]) begin
               nlow++;
               r = 2'(i);
            end
         end
         prs = (nlow == 1);
         if (!m_latched) begin
            if (m_streak > 0 && prs && r == m_row)
               m_streak++;
            else if (m_streak == 0 && prs) begin
               m_streak = 1;
               m_row    = r;
            end else
               m_streak = 0;
            if (m_streak == D) begin
               acc       = 1'b1;
               m_latched = 1'b1;
               m_streak  = 0;
               m_quiet   = 0;
            end
         end else if (!prs) begin
            m_quiet++;
            if (m_quiet == D) begin
               m_latched = 1'b0;
               m_quiet   = 0;
            end
         end else if (r == m_row) begin
            m_quiet = 0;
         end
      end
      m_ovr = 1'b0;
      if (acc && (!m_valid || key_ready)) begin
         m_valid = 1'b1;
         m_code  = {m_row, m_col};
      end else if (acc) begin
         m_ovr = 1'b1;
      end else if (key_ready) begin
         m_valid = 1'b0;
      end
      m_cnt = m_cnt + 8'd1;
   endtask

   task automatic check(input string name,
                        input logic [15:0] got,
                        input logic [15:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %h, expected %h",
                  name, cyc, got, exp);
      end
   endtask

   task automatic tick();
      logic [3:0]  oh;
      logic [10:0] exp;
      @(posedge clk);
      cyc++;
      model_step();
      #1;
      if (model_chk) begin
         oh  = 4'b0001 << m_col;
         exp = {~oh, m_code, m_valid, m_latched, m_ovr};
         tests++;
         if (dut_o !== exp) begin
            fails++;
            if (fails <= 20)
               $display("FAIL model at cycle %0d: got %b, expected %b",
                        cyc, dut_o, exp);
         end
      end
   endtask

   task automatic run_to(input int n);
      while (cyc < n) tick();
   endtask

   task automatic apply_reset(input logic [15:0] keys);
      model_chk = 1'b0;
      key_ready = 1'b0;
      reset     = 1'b0;
      pressed   = keys;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      cyc   = 0;
      model_reset();
   endtask

   // Overrun, or consume-and-accept when rdy is set.
   task automatic overrun_seq(input bit rdy);
      int ovr_cnt;
      apply_reset(16'h0200);
      run_to(1290);
      check("ovr_first_code", 16'(key_code), 16'h9);
      pressed = 16'h0000;
      run_to(2310);
      check("ovr_released",
            16'({col_n, key_held, key_valid}), 16'b1011_0_1);
      pressed = 16'h0040;
      ovr_cnt = 0;
      while (cyc < 3400) begin
         key_ready = (rdy && cyc == 3326);
         tick();
         if (overrun) ovr_cnt++;
      end
      key_ready = 1'b0;
      check("ovr_pulses", 16'(ovr_cnt), rdy ? 16'd0 : 16'd1);
      check("ovr_code", 16'(key_code),
            16'(rdy ? 4'h6 : 4'h9));
      check("ovr_valid_held",
            16'({key_valid, key_held}), 16'b11);
   endtask

   typedef struct {
      logic [15:0] keys;
      int          periods;
      logic [10:0] exp;
   } vec_t;

   vec_t vecs[NV];

   initial begin : main
      int hold_left;
      int held_lost;
      int new_valid;
      int pick;

      vecs[0] = '{16'h0000, 3, {4'b0111, 4'h0, 3'b000}};
      vecs[1] = '{16'h0200, 4, {4'b1101, 4'h0, 3'b000}};
      vecs[2] = '{16'h0200, 8, {4'b1101, 4'h9, 3'b110}};
      vecs[3] = '{16'h0001, 6, {4'b1110, 4'h0, 3'b110}};
      vecs[4] = '{16'h8000, 8, {4'b0111, 4'hF, 3'b110}};
      vecs[5] = '{16'h0044, 8, {4'b1110, 4'h0, 3'b000}};
      vecs[6] = '{16'h0040, 8, {4'b1011, 4'h6, 3'b110}};
      vecs[7] = '{16'h0810, 8, {4'b1110, 4'h4, 3'b110}};
      vecs[8] = '{16'h0001, 4, {4'b1110, 4'h0, 3'b110}};
      vecs[9] = '{16'h0001, 3, {4'b1110, 4'h0, 3'b000}};

      #2;
      check("reset_state", 16'(dut_o),
            16'({4'b1110, 4'h0, 3'b000}));

      for (int i = 0; i < NV; i++) begin
         apply_reset(vecs[i].keys);
         run_to(256 * vecs[i].periods + 10);
         check($sformatf("vec%0d", i),
               16'(dut_o), 16'(vecs[i].exp));
      end

      // Bounce after two agreeing samples.
      apply_reset(16'h0200);
      run_to(700);
      check("bounce_frozen", 16'(col_n), 16'b1101);
      run_to(780);
      pressed = 16'h0000;
      run_to(1034);
      check("bounce_resume",
            16'({col_n, key_valid, key_held}),
            16'b1011_0_0);

      overrun_seq(1'b0);
      overrun_seq(1'b1);

      // Consume, idle ready, short release, full release.
      apply_reset(16'h0200);
      run_to(1290);
      check("rel_accept",
            16'({key_code, key_valid, key_held}),
            16'b1001_1_1);
      key_ready = 1'b1;
      tick();
      key_ready = 1'b0;
      check("rel_consume", 16'(key_valid), 16'd0);
      key_ready = 1'b1;
      tick();
      key_ready = 1'b0;
      check("rel_idle_ready", 16'(key_valid), 16'd0);
      run_to(1300);
      pressed   = 16'h0000;
      held_lost = 0;
      new_valid = 0;
      while (cyc < 2600) begin
         if (cyc == 1800) pressed = 16'h0200;
         tick();
         if (!key_held) held_lost++;
         if (key_valid) new_valid++;
      end
      check("short_rel_held", 16'(held_lost), 16'd0);
      check("short_rel_nokey", 16'(new_valid), 16'd0);
      pressed = 16'h0000;
      run_to(3500);
      check("rel_3_samples", 16'(key_held), 16'd1);
      run_to(3600);
      check("rel_4_samples",
            16'({col_n, key_held}), 16'b1011_0);

      // Asynchronous reset mid-debounce with a key pending.
      apply_reset(16'h0200);
      run_to(1290);
      pressed = 16'h0000;
      run_to(2310);
      pressed = 16'h0040;
      run_to(2900);
      check("mid_debounce",
            16'({col_n, key_valid, key_held}),
            16'b1011_1_0);
      #2;
      reset = 1'b0;
      #1;
      check("async_reset", 16'(dut_o),
            16'({4'b1110, 4'h0, 3'b000}));
      pressed = 16'h0000;
      @(negedge clk);
      reset = 1'b1;
      cyc   = 0;
      model_reset();
      run_to(10);
      check("restart_col0", 16'(col_n), 16'b1110);
      run_to(266);
      check("restart_col1", 16'(col_n), 16'b1101);
      run_to(1034);
      check("restart_wrap",
            16'({col_n, key_valid}), 16'b1110_0);

      // Random keypad activity against the model.
      apply_reset(16'h0000);
      model_chk = 1'b1;
      hold_left = 0;
      while (cyc < 100 * 256) begin
         if (cyc % 256 == 16) begin
            if (hold_left == 0) begin
               pick = $urandom_range(0, 9);
               if (pick < 3)
                  pressed = 16'h0000;
               else if (pick < 8)
                  pressed = 16'h0001 << $urandom_range(0, 15);
               else
                  pressed = (16'h0001 << $urandom_range(0, 15))
                          | (16'h0001 << $urandom_range(0, 15));
               hold_left = $urandom_range(1, 7);
            end else begin
               hold_left--;
            end
         end
         key_ready = ($urandom_range(0, 31) == 0);
         tick();
      end
      model_chk = 1'b0;
      key_ready = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
